// File: rtl/debounce_filter_pkg.sv
// Shared helpers for the debounce filter: counter sizing derived from the
// debounce limit.
package debounce_filter_pkg;

   // Width of the mismatch counter; at least one bit even when the limit is 1.
   function automatic int cnt_width(input int limit);
      return (limit <= 1) ? 1 : $clog2(limit);
   endfunction

endpackage

// File: rtl/debounce_filter_if.sv
// Signal bundle of one debounced line: raw input in, clean level and edge strobes out.
interface debounce_filter_if;
   logic i_in;
   logic o_out;
   logic o_rise;
   logic o_fall;

   modport master (output i_in, input o_out, o_rise, o_fall);
   modport slave  (input i_in, output o_out, o_rise, o_fall);
endinterface

// File: rtl/debounce_filter_sync_chain.sv
// Plain metastability synchronizer: STAGES flops in series, reset to INIT.
module sync_chain #(
   parameter int   STAGES = 2,
   parameter logic INIT   = 1'b1
) (
   input  logic i_clk,
   input  logic i_reset,
   input  logic i_d,
   output logic o_q
);

   logic [STAGES-1:0] q;

   always_ff @(posedge i_clk) begin
      if (i_reset) q <= {STAGES{INIT}};
      else         q <= {q[STAGES-2:0], i_d};
   end

   assign o_q = q[STAGES-1];

endmodule

// File: rtl/debounce_filter.sv
// Debounces one asynchronous line: the output flips only after the synchronized
// sample has disagreed with it for DEBOUNCE_LIMIT consecutive cycles.
module debounce_filter
   import debounce_filter_pkg::*;
#(
   parameter int   DEBOUNCE_LIMIT = 20,
   parameter int   SYNC_STAGES    = 2,
   parameter logic INIT           = 1'b1
) (
   input  logic              i_clk,
   input  logic              i_reset,
   debounce_filter_if.slave  bus
);

   localparam int          CW       = cnt_width(DEBOUNCE_LIMIT);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_LIMIT - 1);

   logic          s;
   logic [CW-1:0] cnt;
   logic          out_q;
   logic          rise_q;
   logic          fall_q;

   sync_chain #(
      .STAGES (SYNC_STAGES),
      .INIT   (INIT)
   ) u_sync (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .i_d     (bus.i_in),
      .o_q     (s)
   );

   // Strobes are registered alongside out_q so they mark the first cycle of the new level.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         cnt    <= '0;
         out_q  <= INIT;
         rise_q <= 1'b0;
         fall_q <= 1'b0;
      end else begin
         rise_q <= 1'b0;
         fall_q <= 1'b0;
         if (s == out_q) begin
            cnt <= '0;
         end else if (cnt == CNT_LAST) begin
            out_q  <= s;
            cnt    <= '0;
            rise_q <= s;
            fall_q <= ~s;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

   assign bus.o_out  = out_q;
   assign bus.o_rise = rise_q;
   assign bus.o_fall = fall_q;

endmodule

// File: tb/tb_debounce_filter.sv
// Bench for debounce_filter: a default instance checked through an edge-strobe
// scoreboard plus inline level checks, and a DEBOUNCE_LIMIT=1 instance.
module tb_debounce_filter;
   import debounce_filter_pkg::*;

   localparam int LAT = 22;

   typedef struct {
      int   cyc;
      logic rise;
   } exp_t;

   logic i_clk;
   logic i_reset;
   int   cyc;
   int   checks;
   int   errors;
   exp_t exp_q[$];

   debounce_filter_if d_if ();
   debounce_filter_if f_if ();

   debounce_filter u_dut (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .bus     (d_if.slave)
   );

   debounce_filter #(
      .DEBOUNCE_LIMIT (1),
      .SYNC_STAGES    (2),
      .INIT           (1'b1)
   ) u_fast (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .bus     (f_if.slave)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   initial cyc = 0;
   always @(posedge i_clk) cyc <= cyc + 1;

   // Scoreboard: every strobe of the default instance must match the next expected event.
   always @(negedge i_clk) begin : monitor
      exp_t e;
      if (!i_reset && (d_if.o_rise || d_if.o_fall)) begin
         checks++;
         if (d_if.o_rise && d_if.o_fall) begin
            errors++;
            $display("FAIL both_strobes cyc=%0d rise=%b fall=%b required one of them", cyc, d_if.o_rise, d_if.o_fall);
         end else if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_strobe cyc=%0d rise=%b fall=%b required none", cyc, d_if.o_rise, d_if.o_fall);
         end else begin
            e = exp_q.pop_front();
            if (e.cyc !== cyc || e.rise !== d_if.o_rise || d_if.o_out !== d_if.o_rise) begin
               errors++;
               $display("FAIL strobe_event got cyc=%0d rise=%b out=%b required cyc=%0d rise=%b", cyc, d_if.o_rise, d_if.o_out, e.cyc, e.rise);
            end
         end
      end
   end

   task automatic wait_until(input int t);
      while (cyc < t) @(negedge i_clk);
   endtask

   task automatic push_exp(input int t, input logic r);
      exp_t e;
      e.cyc  = t;
      e.rise = r;
      exp_q.push_back(e);
   endtask

   task automatic test_reset();
      int c;
      @(negedge i_clk);
      i_reset   = 1'b1;
      d_if.i_in = 1'b0;
      f_if.i_in = 1'b1;
      repeat (3) begin
         @(negedge i_clk);
         checks++;
         if (d_if.o_out !== 1'b1 || d_if.o_rise !== 1'b0 || d_if.o_fall !== 1'b0) begin
            errors++;
            $display("FAIL reset_state out=%b rise=%b fall=%b required 1 0 0", d_if.o_out, d_if.o_rise, d_if.o_fall);
         end
      end
      i_reset = 1'b0;
      c = cyc;
      push_exp(c + LAT, 1'b0);
      wait_until(c + LAT - 1);
      checks++;
      if (d_if.o_out !== 1'b1) begin
         errors++;
         $display("FAIL reset_release_early out=%b required 1", d_if.o_out);
      end
      @(negedge i_clk);
      checks++;
      if (d_if.o_out !== 1'b0) begin
         errors++;
         $display("FAIL reset_release_fall out=%b required 0", d_if.o_out);
      end
   endtask

   task automatic test_edges();
      int c;
      for (int i = 0; i < 3; i++) begin
         logic v;
         v = (i % 2 == 0);
         @(negedge i_clk);
         d_if.i_in = v;
         c = cyc;
         push_exp(c + LAT, v);
         wait_until(c + LAT - 1);
         checks++;
         if (d_if.o_out !== ~v) begin
            errors++;
            $display("FAIL edge_hold_21 step=%0d out=%b required %b", i, d_if.o_out, ~v);
         end
         @(negedge i_clk);
         checks++;
         if (d_if.o_out !== v) begin
            errors++;
            $display("FAIL edge_update_22 step=%0d out=%b required %b", i, d_if.o_out, v);
         end
      end
   endtask

   task automatic test_glitch();
      int c;
      // 19-cycle low pulse must vanish entirely
      @(negedge i_clk);
      d_if.i_in = 1'b0;
      c = cyc;
      wait_until(c + 19);
      d_if.i_in = 1'b1;
      wait_until(c + 50);
      checks++;
      if (d_if.o_out !== 1'b1 || exp_q.size() != 0) begin
         errors++;
         $display("FAIL glitch_19 out=%b pending=%0d required out 1 pending 0", d_if.o_out, exp_q.size());
      end
      // 20-cycle low pulse just passes
      d_if.i_in = 1'b0;
      c = cyc;
      push_exp(c + LAT, 1'b0);
      wait_until(c + 20);
      d_if.i_in = 1'b1;
      push_exp(c + 20 + LAT, 1'b1);
      wait_until(c + 20 + LAT + 3);
      checks++;
      if (d_if.o_out !== 1'b1 || exp_q.size() != 0) begin
         errors++;
         $display("FAIL glitch_20 out=%b pending=%0d required out 1 pending 0", d_if.o_out, exp_q.size());
      end
   endtask

   task automatic test_reset_midcount();
      int c;
      @(negedge i_clk);
      d_if.i_in = 1'b0;
      c = cyc;
      wait_until(c + 17);
      i_reset = 1'b1;
      repeat (3) begin
         @(negedge i_clk);
         checks++;
         if (d_if.o_out !== 1'b1 || d_if.o_fall !== 1'b0) begin
            errors++;
            $display("FAIL midcount_reset out=%b fall=%b required 1 0", d_if.o_out, d_if.o_fall);
         end
      end
      i_reset = 1'b0;
      c = cyc;
      push_exp(c + LAT, 1'b0);
      wait_until(c + LAT - 1);
      checks++;
      if (d_if.o_out !== 1'b1) begin
         errors++;
         $display("FAIL midcount_full_latency out=%b required 1", d_if.o_out);
      end
      @(negedge i_clk);
      checks++;
      if (d_if.o_out !== 1'b0) begin
         errors++;
         $display("FAIL midcount_fall out=%b required 0", d_if.o_out);
      end
   endtask

   task automatic test_back_to_back();
      int c;
      @(negedge i_clk);
      c = cyc;
      for (int i = 0; i < 3; i++) begin
         d_if.i_in = (i % 2 == 0);
         push_exp(c + (i + 1) * LAT, (i % 2 == 0));
         wait_until(c + (i + 1) * LAT);
      end
      wait_until(c + 4 * LAT);
      checks++;
      if (d_if.o_out !== 1'b1 || exp_q.size() != 0) begin
         errors++;
         $display("FAIL back_to_back out=%b pending=%0d required out 1 pending 0", d_if.o_out, exp_q.size());
      end
   endtask

   task automatic test_chatter();
      int c;
      for (int seg = 0; seg < 40; seg++) begin
         @(negedge i_clk);
         d_if.i_in = (seg % 2 == 1);
         repeat (4) @(negedge i_clk);
      end
      @(negedge i_clk);
      d_if.i_in = 1'b0;
      c = cyc;
      push_exp(c + LAT, 1'b0);
      wait_until(c + LAT + 5);
      checks++;
      if (d_if.o_out !== 1'b0 || exp_q.size() != 0) begin
         errors++;
         $display("FAIL chatter out=%b pending=%0d required out 0 pending 0", d_if.o_out, exp_q.size());
      end
   endtask

   task automatic test_limit1();
      logic v [0:67];
      for (int j = 0; j < 68; j++) v[j] = 1'b1;
      for (int j = 0; j < 64; j++) begin
         logic ex_o;
         logic ex_r;
         logic ex_f;
         @(negedge i_clk);
         // index offset 4: entries 0..3 stand for the idle level before the run
         ex_o = v[j + 1];
         ex_r = v[j + 1] & ~v[j];
         ex_f = ~v[j + 1] & v[j];
         checks++;
         if (f_if.o_out !== ex_o || f_if.o_rise !== ex_r || f_if.o_fall !== ex_f) begin
            errors++;
            $display("FAIL limit1 j=%0d out=%b rise=%b fall=%b required %b %b %b", j, f_if.o_out, f_if.o_rise, f_if.o_fall, ex_o, ex_r, ex_f);
         end
         v[j + 4]  = (j < 16) ? (j % 2 == 0) : 1'($urandom_range(0, 1));
         f_if.i_in = v[j + 4];
      end
   endtask

   initial begin
      checks    = 0;
      errors    = 0;
      i_reset   = 1'b1;
      d_if.i_in = 1'b1;
      f_if.i_in = 1'b1;
      test_reset();
      test_edges();
      test_glitch();
      test_reset_midcount();
      test_back_to_back();
      test_chatter();
      test_limit1();
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL leftover_events pending=%0d required 0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
